// File: rtl/cart_header_probe.sv
// Boot-time cartridge header probe: reads the logo LOGO_PASSES times, then header $0134-$014D.
// Latency: 1 + (48*LOGO_PASSES+26)*(READ_WAIT+1) ce_cpu pulses from accepted start to done.
// Backpressure: none; ce_cpu low freezes every register, start while busy is ignored.
module cart_header_probe #(
  parameter int READ_WAIT   = 2,
  parameter int LOGO_PASSES = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_cpu,
  input  logic        start,
  output logic [14:0] cart_addr,
  output logic        cart_a15,
  output logic        cart_rd,
  output logic        cart_wr,
  input  logic [7:0]  rom_data,
  output logic        busy,
  output logic        done,
  output logic        logo_ok,
  output logic        hdr_chk_ok,
  output logic [7:0]  cgb_flag,
  output logic [7:0]  cart_mbc_type,
  output logic [7:0]  rom_size,
  output logic [7:0]  ram_size
);

  localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [14:0] LOGO_BASE = 15'h0104;
  localparam logic [14:0] HDR_BASE  = 15'h0134;
  localparam logic [WW-1:0] WLAST   = WW'(READ_WAIT - 1);
  localparam logic [1:0] NPASS      = 2'(LOGO_PASSES);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_GAP} state_t;

  // Reference DMG boot logo, indexed by byte offset from $0104.
  function automatic logic [7:0] logo_byte(input logic [5:0] i);
    logic [7:0] b;
    case (i)
      6'd0:  b = 8'hCE; 6'd1:  b = 8'hED; 6'd2:  b = 8'h66; 6'd3:  b = 8'h66;
      6'd4:  b = 8'hCC; 6'd5:  b = 8'h0D; 6'd6:  b = 8'h00; 6'd7:  b = 8'h0B;
      6'd8:  b = 8'h03; 6'd9:  b = 8'h73; 6'd10: b = 8'h00; 6'd11: b = 8'h83;
      6'd12: b = 8'h00; 6'd13: b = 8'h0C; 6'd14: b = 8'h00; 6'd15: b = 8'h0D;
      6'd16: b = 8'h00; 6'd17: b = 8'h08; 6'd18: b = 8'h11; 6'd19: b = 8'h1F;
      6'd20: b = 8'h88; 6'd21: b = 8'h89; 6'd22: b = 8'h00; 6'd23: b = 8'h0E;
      6'd24: b = 8'hDC; 6'd25: b = 8'hCC; 6'd26: b = 8'h6E; 6'd27: b = 8'hE6;
      6'd28: b = 8'hDD; 6'd29: b = 8'hDD; 6'd30: b = 8'hD9; 6'd31: b = 8'h99;
      6'd32: b = 8'hBB; 6'd33: b = 8'hBB; 6'd34: b = 8'h67; 6'd35: b = 8'h63;
      6'd36: b = 8'h6E; 6'd37: b = 8'h0E; 6'd38: b = 8'hEC; 6'd39: b = 8'hCC;
      6'd40: b = 8'hDD; 6'd41: b = 8'hDC; 6'd42: b = 8'h99; 6'd43: b = 8'h9F;
      6'd44: b = 8'hBB; 6'd45: b = 8'hB9; 6'd46: b = 8'h33; 6'd47: b = 8'h3E;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t        state_q, state_d;
  logic [14:0]   addr_q, addr_d;
  logic          a15_q, a15_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [5:0]    idx_q, idx_d;
  logic [1:0]    pass_q, pass_d;
  logic          mismatch_q, mismatch_d;
  logic [7:0]    chk_q, chk_d;
  logic          chk_eq_q, chk_eq_d;
  logic          logo_ok_q, logo_ok_d;
  logic          hdr_ok_q, hdr_ok_d;
  logic [7:0]    cgb_q, cgb_d;
  logic [7:0]    mbc_q, mbc_d;
  logic [7:0]    rsz_q, rsz_d;
  logic [7:0]    asz_q, asz_d;

  // Once every logo pass is done, pass_q sits at LOGO_PASSES and idx walks the header.
  logic hdr_phase;
  logic last_byte;
  assign hdr_phase = (pass_q == NPASS);
  assign last_byte = hdr_phase && (idx_q == 6'd25);

  // Next-state and datapath: everything holds unless ce_cpu is high.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    a15_d      = a15_q;
    rd_d       = rd_q;
    busy_d     = busy_q;
    done_d     = done_q;
    wcnt_d     = wcnt_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    mismatch_d = mismatch_q;
    chk_d      = chk_q;
    chk_eq_d   = chk_eq_q;
    logo_ok_d  = logo_ok_q;
    hdr_ok_d   = hdr_ok_q;
    cgb_d      = cgb_q;
    mbc_d      = mbc_q;
    rsz_d      = rsz_q;
    asz_d      = asz_q;
    if (ce_cpu) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_d     = LOGO_BASE;
            a15_d      = 1'b0;
            rd_d       = 1'b1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            wcnt_d     = '0;
            pass_d     = 2'd0;
            idx_d      = 6'd0;
            mismatch_d = 1'b0;
            chk_d      = 8'h00;
            chk_eq_d   = 1'b0;
            logo_ok_d  = 1'b0;
            hdr_ok_d   = 1'b0;
            state_d    = S_ADDR;
          end
        end
        S_ADDR: begin
          if (wcnt_q != WLAST) begin
            wcnt_d = wcnt_q + 1'b1;
          end else begin
            // Last wait pulse: the mapper's data is settled, take it and release A15.
            a15_d   = 1'b1;
            rd_d    = 1'b0;
            state_d = S_GAP;
            if (!hdr_phase) begin
              mismatch_d = mismatch_q | (rom_data != logo_byte(idx_q));
            end else if (idx_q == 6'd25) begin
              chk_eq_d = (chk_q == rom_data);
            end else begin
              chk_d = chk_q - rom_data - 8'd1;
            end
            if (hdr_phase) begin
              if (addr_q == 15'h0143) cgb_d = rom_data;
              if (addr_q == 15'h0147) mbc_d = rom_data;
              if (addr_q == 15'h0148) rsz_d = rom_data;
              if (addr_q == 15'h0149) asz_d = rom_data;
            end
          end
        end
        S_GAP: begin
          if (last_byte) begin
            busy_d    = 1'b0;
            done_d    = 1'b1;
            logo_ok_d = ~mismatch_q;
            hdr_ok_d  = chk_eq_q;
            state_d   = S_IDLE;
          end else begin
            a15_d   = 1'b0;
            rd_d    = 1'b1;
            wcnt_d  = '0;
            state_d = S_ADDR;
            if (!hdr_phase && (idx_q == 6'd47)) begin
              // End of a logo pass: either start the next pass or move on to the header.
              idx_d  = 6'd0;
              pass_d = pass_q + 2'd1;
              addr_d = ((pass_q + 2'd1) == NPASS) ? HDR_BASE : LOGO_BASE;
            end else begin
              idx_d  = idx_q + 6'd1;
              addr_d = addr_q + 15'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset parks the bus with A15 high and no read strobe.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 15'h0000;
      a15_q      <= 1'b1;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wcnt_q     <= '0;
      idx_q      <= 6'd0;
      pass_q     <= 2'd0;
      mismatch_q <= 1'b0;
      chk_q      <= 8'h00;
      chk_eq_q   <= 1'b0;
      logo_ok_q  <= 1'b0;
      hdr_ok_q   <= 1'b0;
      cgb_q      <= 8'h00;
      mbc_q      <= 8'h00;
      rsz_q      <= 8'h00;
      asz_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      a15_q      <= a15_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wcnt_q     <= wcnt_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      mismatch_q <= mismatch_d;
      chk_q      <= chk_d;
      chk_eq_q   <= chk_eq_d;
      logo_ok_q  <= logo_ok_d;
      hdr_ok_q   <= hdr_ok_d;
      cgb_q      <= cgb_d;
      mbc_q      <= mbc_d;
      rsz_q      <= rsz_d;
      asz_q      <= asz_d;
    end
  end

  assign cart_addr     = addr_q;
  assign cart_a15      = a15_q;
  assign cart_rd       = rd_q;
  assign cart_wr       = 1'b0;
  assign busy          = busy_q;
  assign done          = done_q;
  assign logo_ok       = logo_ok_q;
  assign hdr_chk_ok    = hdr_ok_q;
  assign cgb_flag      = cgb_q;
  assign cart_mbc_type = mbc_q;
  assign rom_size      = rsz_q;
  assign ram_size      = asz_q;

endmodule

// File: tb/tb_cart_header_probe.sv
// Bench for cart_header_probe: two instances (2 passes/wait 2 and 1 pass/wait 1) against a ROM model.
// Expected results come from the ROM image at issue time and go through a scoreboard queue.
// A negedge monitor counts ce pulses and A15 edges per probe and checks each completion.
module tb_cart_header_probe;

  localparam int RW [2] = '{2, 1};
  localparam int LP [2] = '{2, 1};
  localparam logic [7:0] LOGO [48] = '{
    8'hCE, 8'hED, 8'h66, 8'h66, 8'hCC, 8'h0D, 8'h00, 8'h0B, 8'h03, 8'h73, 8'h00, 8'h83,
    8'h00, 8'h0C, 8'h00, 8'h0D, 8'h00, 8'h08, 8'h11, 8'h1F, 8'h88, 8'h89, 8'h00, 8'h0E,
    8'hDC, 8'hCC, 8'h6E, 8'hE6, 8'hDD, 8'hDD, 8'hD9, 8'h99, 8'hBB, 8'hBB, 8'h67, 8'h63,
    8'h6E, 8'h0E, 8'hEC, 8'hCC, 8'hDD, 8'hDC, 8'h99, 8'h9F, 8'hBB, 8'hB9, 8'h33, 8'h3E};

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ce [2];
  logic        start [2];
  logic [14:0] addr [2];
  logic        a15 [2], rd [2], wr [2];
  logic [7:0]  rdat [2];
  logic        busy [2], done [2], lok [2], hok [2];
  logic [7:0]  cgb [2], mbc [2], rsz [2], asz [2];

  logic [7:0]  mem [2][128];
  logic        corrupt [2];
  int          seen [2];

  typedef struct {
    int         inst;
    logic       lok;
    logic       hok;
    logic [7:0] cgb, mbc, rsz, asz;
    int         ce_n;
    int         edges;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  cart_header_probe #(.READ_WAIT(2), .LOGO_PASSES(2)) u0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce[0]), .start(start[0]),
    .cart_addr(addr[0]), .cart_a15(a15[0]), .cart_rd(rd[0]), .cart_wr(wr[0]),
    .rom_data(rdat[0]), .busy(busy[0]), .done(done[0]), .logo_ok(lok[0]),
    .hdr_chk_ok(hok[0]), .cgb_flag(cgb[0]), .cart_mbc_type(mbc[0]),
    .rom_size(rsz[0]), .ram_size(asz[0]));

  cart_header_probe #(.READ_WAIT(1), .LOGO_PASSES(1)) u1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce[1]), .start(start[1]),
    .cart_addr(addr[1]), .cart_a15(a15[1]), .cart_rd(rd[1]), .cart_wr(wr[1]),
    .rom_data(rdat[1]), .busy(busy[1]), .done(done[1]), .logo_ok(lok[1]),
    .hdr_chk_ok(hok[1]), .cgb_flag(cgb[1]), .cart_mbc_type(mbc[1]),
    .rom_size(rsz[1]), .ram_size(asz[1]));

  // ROM model: image for $0100-$014F; optional fault flips $011F after its first read.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rdat[k] = 8'hFF;
      if (addr[k] >= 15'h0100 && addr[k] < 15'h0150) rdat[k] = mem[k][addr[k][6:0]];
      if (corrupt[k] && addr[k] == 15'h011F && seen[k] != 0) rdat[k] = rdat[k] ^ 8'h01;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: per-probe ce/edge bookkeeping and scoreboard pop on each done rising edge.
  int   ce_cnt [2], edges [2], rdbad [2];
  logic busy_p [2], done_p [2], a15_p [2], ce_p [2];
  initial begin
    for (int k = 0; k < 2; k++) begin
      ce_cnt[k] = 0; edges[k] = 0; rdbad[k] = 0;
      busy_p[k] = 0; done_p[k] = 0; a15_p[k] = 1; ce_p[k] = 0;
    end
    forever begin
      @(negedge clk_sys);
      for (int k = 0; k < 2; k++) begin
        if (busy[k] && !busy_p[k]) begin
          ce_cnt[k] = 1; edges[k] = 0; rdbad[k] = 0;
          check($sformatf("u%0d results cleared on start", k), {61'd0, done[k], lok[k], hok[k]}, 64'd0);
        end else if (busy_p[k] && ce_p[k]) begin
          ce_cnt[k]++;
        end
        if (a15[k] && !a15_p[k]) begin
          edges[k]++;
          if (addr[k] == 15'h011F) seen[k]++;
        end
        if (rd[k] !== !a15[k]) rdbad[k]++;
        if (done[k] && !done_p[k]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("u%0d unexpected done", k), 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("instance", 64'(k), 64'(e.inst));
            check($sformatf("u%0d logo_ok", k), 64'(lok[k]), 64'(e.lok));
            check($sformatf("u%0d hdr_chk_ok", k), 64'(hok[k]), 64'(e.hok));
            check($sformatf("u%0d cgb_flag", k), 64'(cgb[k]), 64'(e.cgb));
            check($sformatf("u%0d mbc_type", k), 64'(mbc[k]), 64'(e.mbc));
            check($sformatf("u%0d rom_size", k), 64'(rsz[k]), 64'(e.rsz));
            check($sformatf("u%0d ram_size", k), 64'(asz[k]), 64'(e.asz));
            check($sformatf("u%0d ce pulses to done", k), 64'(ce_cnt[k]), 64'(e.ce_n));
            check($sformatf("u%0d a15 rising edges", k), 64'(edges[k]), 64'(e.edges));
            check($sformatf("u%0d rd vs a15 violations", k), 64'(rdbad[k]), 64'd0);
          end
        end
        busy_p[k] = busy[k]; done_p[k] = done[k]; a15_p[k] = a15[k]; ce_p[k] = ce[k];
      end
    end
  end

  // One clock of stimulus: random ce, occasional start pulses while busy (must be ignored).
  task automatic tick(input int k);
    @(posedge clk_sys);
    #1;
    ce[k]    = ($urandom_range(0, 3) != 0);
    start[k] = busy[k] ? ($urandom_range(0, 7) == 0) : 1'b0;
  endtask

  // mode 0: good ROM ($0147=0x97), 1: $011F wrong on second read, 2: checksum+1, 3: bad logo byte
  task automatic run_probe(input int k, input int mode, input bit freeze, input bit abort);
    exp_t        e;
    int          sum;
    bit          ok;
    bit          fin;
    logic [63:0] snap;
    for (int i = 0; i < 128; i++) mem[k][i] = 8'($urandom);
    for (int i = 0; i < 48; i++) mem[k][4 + i] = LOGO[i];
    if (mode == 0) mem[k][7'h47] = 8'h97;
    if (mode == 3) mem[k][4 + $urandom_range(0, 47)] ^= 8'($urandom_range(1, 255));
    sum = 0;
    for (int a = 7'h34; a <= 7'h4C; a++) sum += int'(mem[k][a]);
    mem[k][7'h4D] = 8'(-sum - 25 + ((mode == 2) ? 1 : 0));
    corrupt[k] = (mode == 1);
    seen[k]    = 0;
    // Reference: header checksum = -(sum of 25 bytes) - 25; logo must match on every pass.
    ok = 1'b1;
    for (int i = 0; i < 48; i++) if (mem[k][4 + i] != LOGO[i]) ok = 1'b0;
    if (corrupt[k] && LP[k] >= 2) ok = 1'b0;
    e.inst  = k;
    e.lok   = ok;
    e.hok   = (mem[k][7'h4D] == 8'(-sum - 25));
    e.cgb   = mem[k][7'h43];
    e.mbc   = mem[k][7'h47];
    e.rsz   = mem[k][7'h48];
    e.asz   = mem[k][7'h49];
    e.edges = 48 * LP[k] + 26;
    e.ce_n  = 1 + e.edges * (RW[k] + 1);
    exp_q.push_back(e);
    @(posedge clk_sys);
    #1;
    start[k] = 1'b1;
    ce[k]    = 1'b1;
    fin = 1'b0;
    for (int n = 0; n < 3000 && !fin; n++) begin
      tick(k);
      if (abort && busy[k] && addr[k] == 15'h0118 && !a15[k]) begin
        #2;
        reset_n = 1'b0;
        #1;
        check("abort a15/rd/busy/done/logo_ok", {59'd0, a15[k], rd[k], busy[k], done[k], lok[k]},
              {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        ce[k] = 1'b0; start[k] = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        void'(exp_q.pop_back());
        return;
      end
      if (freeze && n == 100) begin
        ce[k] = 1'b0; start[k] = 1'b0;
        snap = {11'd0, addr[k], a15[k], rd[k], busy[k], done[k], lok[k], hok[k],
                cgb[k], mbc[k], rsz[k], asz[k]};
        repeat (50) @(posedge clk_sys);
        #1;
        check("outputs frozen with ce low",
              {11'd0, addr[k], a15[k], rd[k], busy[k], done[k], lok[k], hok[k],
               cgb[k], mbc[k], rsz[k], asz[k]}, snap);
      end
      if (done[k] && !busy[k]) fin = 1'b1;
    end
    if (!fin) check($sformatf("u%0d probe timeout", k), 64'd1, 64'd0);
    repeat (3) tick(k);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ce[k] = 1'b0; start[k] = 1'b0; corrupt[k] = 1'b0; seen[k] = 0;
      for (int i = 0; i < 128; i++) mem[k][i] = 8'h00;
    end
    repeat (3) @(posedge clk_sys);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d reset addr/a15/rd/wr", k), {45'd0, addr[k], a15[k], rd[k], wr[k]},
            {45'd0, 15'h0000, 1'b1, 1'b0, 1'b0});
      check($sformatf("u%0d reset busy/done/ok", k), {60'd0, busy[k], done[k], lok[k], hok[k]}, 64'd0);
      check($sformatf("u%0d reset fields", k), {32'd0, cgb[k], mbc[k], rsz[k], asz[k]}, 64'd0);
    end
    reset_n = 1'b1;
    run_probe(0, 0, 1'b0, 1'b0);
    run_probe(0, 1, 1'b0, 1'b0);
    run_probe(0, 2, 1'b0, 1'b0);
    run_probe(0, 0, 1'b1, 1'b0);
    run_probe(0, 0, 1'b0, 1'b1);
    run_probe(0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_probe(0, $urandom_range(0, 3), 1'b0, 1'b0);
    run_probe(1, 0, 1'b0, 1'b0);
    run_probe(1, 1, 1'b0, 1'b0);
    run_probe(1, 2, 1'b0, 1'b0);
    run_probe(1, 3, 1'b0, 1'b0);
    repeat (5) @(posedge clk_sys);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
